theta_sweep_gen: RTL

THETA_SWEEP_GEN -- requirements
Module: theta_sweep_gen

---
 rtl/cordic_pkg.sv | 22 ++
 rtl/theta_wrap.sv | 50 +++++
 rtl/theta_sweep_gen.sv | 86 ++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cordic_pkg
// Brief    : Shared angle-format constants and sweep FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package cordic_pkg;

  // Angles are signed Q16.16 radians.
  localparam int THETA_WIDTH = 32;
  localparam int FRAC_BITS   = 16;
  localparam int PI_Q        = 205887;
  localparam int TWO_PI_Q    = 411775;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/theta_wrap.sv
`default_nettype none
// ============================================================================
// Module   : theta_wrap
// Brief    : Combinational angle add with optional fold into [-pi, pi).
//            Folding is enabled by defining THETA_WRAP_EN; otherwise the sum
//            wraps as plain two's complement.
// Revision : 1.0 - initial release
// ============================================================================
module theta_wrap #(
  parameter int THETA_WIDTH = 32
) (
  input  logic signed [THETA_WIDTH-1:0] acc,
  input  logic signed [THETA_WIDTH-1:0] step,
  output logic signed [THETA_WIDTH-1:0] next
);
  import cordic_pkg::*;

  localparam logic signed [THETA_WIDTH:0] c_pi_q     = (THETA_WIDTH+1)'(PI_Q);
  localparam logic signed [THETA_WIDTH:0] c_two_pi_q = (THETA_WIDTH+1)'(TWO_PI_Q);

  // One guard bit so the sum itself can never overflow before folding.
  logic signed [THETA_WIDTH:0] w_sum;
  assign w_sum = {acc[THETA_WIDTH-1], acc} + {step[THETA_WIDTH-1], step};

`ifdef THETA_WRAP_EN
  logic signed [THETA_WIDTH:0] w_fold;

  // A single fold suffices because |step| < 2*pi and acc is already in range.
  always_comb begin
    w_fold = w_sum;
    if (w_sum >= c_pi_q) begin
      w_fold = w_sum - c_two_pi_q;
    end else if (w_sum < -c_pi_q) begin
      w_fold = w_sum + c_two_pi_q;
    end
  end

  logic w_unused_msb;
  assign w_unused_msb = w_fold[THETA_WIDTH];
  assign next         = w_fold[THETA_WIDTH-1:0];
`else
  logic w_unused_msb;
  logic w_unused_consts;
  assign w_unused_msb    = w_sum[THETA_WIDTH];
  assign w_unused_consts = c_pi_q[0] ^ c_two_pi_q[0];
  assign next            = w_sum[THETA_WIDTH-1:0];
`endif

endmodule
`default_nettype wire

// File: rtl/theta_sweep_gen.sv
`default_nettype none
// ============================================================================
// Module   : theta_sweep_gen
// Brief    : Emits count angles theta_start + k*theta_step into a FIFO,
//            stalling on theta_full. Optional fold into [-pi, pi) when
//            THETA_WRAP_EN is defined (see theta_wrap).
// Revision : 1.0 - initial release
// ============================================================================
module theta_sweep_gen #(
  parameter int THETA_WIDTH = cordic_pkg::THETA_WIDTH,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic signed [THETA_WIDTH-1:0] theta_start,
  input  logic signed [THETA_WIDTH-1:0] theta_step,
  input  logic        [COUNT_WIDTH-1:0] count,
  output logic                          busy,
  output logic                          done,
  input  logic                          theta_full,
  output logic                          theta_wr_en,
  output logic signed [THETA_WIDTH-1:0] theta_out
);
  import cordic_pkg::*;

  state_t                        r_state;
  logic signed [THETA_WIDTH-1:0] r_acc;
  logic signed [THETA_WIDTH-1:0] r_step;
  logic        [COUNT_WIDTH-1:0] r_remaining;
  logic signed [THETA_WIDTH-1:0] w_acc_next;
  logic                          w_write;

  theta_wrap #(
    .THETA_WIDTH (THETA_WIDTH)
  ) u_theta_wrap (
    .acc  (r_acc),
    .step (r_step),
    .next (w_acc_next)
  );

  // Write strobe is combinational on theta_full so a full FIFO is never written.
  assign w_write     = (r_state == RUN) && !theta_full;
  assign theta_wr_en = w_write;
  assign theta_out   = r_acc;
  assign busy        = (r_state != IDLE);
  assign done        = (r_state == DONE);

  // Sweep control: latch on start in IDLE, advance only on accepted writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_step      <= '0;
      r_remaining <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_acc       <= theta_start;
            r_step      <= theta_step;
            r_remaining <= count;
            r_state     <= (count != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (w_write) begin
            r_acc       <= w_acc_next;
            r_remaining <= r_remaining - COUNT_WIDTH'(1);
            if (r_remaining == COUNT_WIDTH'(1)) begin
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
